vga_scanout: RTL

//  Downstream consumer of the 256x240 3-bit frame-buffer RAM.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_scanout_if.sv | 41 ++++
 rtl/vga_timing.sv | 75 +++++++
 rtl/vga_scanout.sv | 139 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, 3-bit colour type and DAC bit expansion.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Buffer is 256 pixels wide, each shown twice horizontally.
  localparam int FB_WIN_W  = 512;
  localparam int DAC_MAX_W = 16;

  typedef logic [2:0] rgb3_t;

  typedef struct packed {
    logic [DAC_MAX_W-1:0] r;
    logic [DAC_MAX_W-1:0] g;
    logic [DAC_MAX_W-1:0] b;
  } dac_t;

  // Callers truncate each channel to their own DAC width.
  function automatic dac_t rgb3_to_dac(rgb3_t c);
    dac_t d;
    d.r = {DAC_MAX_W{c[2]}};
    d.g = {DAC_MAX_W{c[1]}};
    d.b = {DAC_MAX_W{c[0]}};
    return d;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port plus VGA pin bundle; test_sel exists only with SCANOUT_TESTPAT_EN.
interface vga_scanout_if #(
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 4
);
  import vga_pkg::*;

  rgb3_t              pix_data;
  logic [ADDR_W-1:0]  rAddr;
  logic               RE;
  logic               vga_hsync;
  logic               vga_vsync;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               vga_blank_n;
  logic               frame_start;
  logic               vblank;
`ifdef SCANOUT_TESTPAT_EN
  logic               test_sel;
`endif

  modport master (
    input  pix_data,
`ifdef SCANOUT_TESTPAT_EN
    input  test_sel,
`endif
    output rAddr, RE, vga_hsync, vga_vsync, vga_r, vga_g, vga_b,
    output vga_blank_n, frame_start, vblank
  );

  modport slave (
    output pix_data,
`ifdef SCANOUT_TESTPAT_EN
    output test_sel,
`endif
    input  rAddr, RE, vga_hsync, vga_vsync, vga_r, vga_g, vga_b,
    input  vga_blank_n, frame_start, vblank
  );

endinterface

// File: rtl/vga_timing.sv
// Pixel-strobe divider and 800x525 raster counters with raw sync/active decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_tick,
  output logic [9:0] o_hcount,
  output logic [9:0] o_vcount,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_active,
  output logic       o_frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] L_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] L_HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] L_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] L_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] L_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hcount;
  logic [9:0]       r_vcount;
  logic             r_frame_start;
  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;

  assign w_tick   = (r_div == L_DIV_LAST);
  assign w_h_last = (r_hcount == L_H_LAST);
  assign w_v_last = (r_vcount == L_V_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_hcount <= '0;
        r_vcount <= w_v_last ? 10'd0 : r_vcount + 10'd1;
      end else begin
        r_hcount <= r_hcount + 10'd1;
      end
    end
  end

  // Registered so the pulse coincides with the counters already sitting at (0,0).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_frame_start <= 1'b0;
    else       r_frame_start <= w_tick & w_h_last & w_v_last;
  end

  assign o_tick        = w_tick;
  assign o_hcount      = r_hcount;
  assign o_vcount      = r_vcount;
  assign o_hsync       = !((r_hcount >= L_HS_BEG) && (r_hcount < L_HS_END));
  assign o_vsync       = !((r_vcount >= L_VS_BEG) && (r_vcount < L_VS_END));
  assign o_active      = (r_hcount < L_H_ACT) && (r_vcount < L_V_ACT);
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_scanout.sv
// 256x240 frame-buffer scanout to 640x480 VGA, 2x2 pixels, 64-px side borders.
// Optional SCANOUT_TESTPAT_EN adds test_sel for an 8-bar pattern without RAM reads.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int COLOR_W  = 4,
  parameter int ADDR_W   = 17,
  parameter int H_OFFSET = 64
) (
  input  logic          clock,
  input  logic          reset,
  vga_scanout_if.master bus
);

  localparam logic [9:0] L_WIN_BEG = 10'(H_OFFSET);
  localparam logic [9:0] L_WIN_END = 10'(H_OFFSET + FB_WIN_W);
  localparam logic [9:0] L_V_ACT   = 10'(V_ACTIVE);

  logic       w_tick;
  logic [9:0] w_hcount;
  logic [9:0] w_vcount;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_active;
  logic       w_frame_start;
  logic       w_in_win;
  logic       w_rd;
  logic [7:0] w_fb_x;
  logic [7:0] w_fb_y;
  rgb3_t      w_colour;
  dac_t       w_dac;

  logic [ADDR_W-1:0]  r_addr_p1;
  logic               r_vld_p1;
  logic               r_hs_p1;
  logic               r_vs_p1;
  logic               r_act_p1;
  logic               r_win_p1;
  logic               r_hs_p2;
  logic               r_vs_p2;
  logic               r_act_p2;
  logic [COLOR_W-1:0] r_r_p2;
  logic [COLOR_W-1:0] r_g_p2;
  logic [COLOR_W-1:0] r_b_p2;
`ifdef SCANOUT_TESTPAT_EN
  logic               r_tp_p1;
  rgb3_t              r_bar_p1;
`endif

  vga_timing #(.CLK_DIV(CLK_DIV)) u_tim (
    .i_clk         (clock),
    .i_rst         (reset),
    .o_tick        (w_tick),
    .o_hcount      (w_hcount),
    .o_vcount      (w_vcount),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_active      (w_active),
    .o_frame_start (w_frame_start)
  );

  assign w_in_win = (w_hcount >= L_WIN_BEG) && (w_hcount < L_WIN_END) && (w_vcount < L_V_ACT);
  assign w_fb_x   = 8'((w_hcount - L_WIN_BEG) >> 1);
  assign w_fb_y   = 8'(w_vcount >> 1);
`ifdef SCANOUT_TESTPAT_EN
  assign w_rd     = w_in_win && !bus.test_sel;
`else
  assign w_rd     = w_in_win;
`endif

  // Stage 1: issue RAM read, register raster decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_hs_p1   <= 1'b1;
      r_vs_p1   <= 1'b1;
      r_act_p1  <= 1'b0;
      r_win_p1  <= 1'b0;
`ifdef SCANOUT_TESTPAT_EN
      r_tp_p1   <= 1'b0;
      r_bar_p1  <= '0;
`endif
    end else begin
      r_vld_p1 <= w_tick & w_rd;
      if (w_tick) begin
        if (w_rd) r_addr_p1 <= ADDR_W'({w_fb_y, w_fb_x});
        r_hs_p1  <= w_hsync;
        r_vs_p1  <= w_vsync;
        r_act_p1 <= w_active;
        r_win_p1 <= w_in_win;
`ifdef SCANOUT_TESTPAT_EN
        r_tp_p1  <= bus.test_sel;
        r_bar_p1 <= w_fb_x[7:5];
`endif
      end
    end
  end

`ifdef SCANOUT_TESTPAT_EN
  assign w_colour = r_tp_p1 ? r_bar_p1 : bus.pix_data;
`else
  assign w_colour = bus.pix_data;
`endif
  assign w_dac = rgb3_to_dac(w_colour);

  // Stage 2: capture RAM data, expand colour, align with syncs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hs_p2  <= 1'b1;
      r_vs_p2  <= 1'b1;
      r_act_p2 <= 1'b0;
      r_r_p2   <= '0;
      r_g_p2   <= '0;
      r_b_p2   <= '0;
    end else if (w_tick) begin
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_act_p2 <= r_act_p1;
      r_r_p2   <= r_win_p1 ? COLOR_W'(w_dac.r) : '0;
      r_g_p2   <= r_win_p1 ? COLOR_W'(w_dac.g) : '0;
      r_b_p2   <= r_win_p1 ? COLOR_W'(w_dac.b) : '0;
    end
  end

  assign bus.rAddr       = r_addr_p1;
  assign bus.RE          = r_vld_p1;
  assign bus.vga_hsync   = r_hs_p2;
  assign bus.vga_vsync   = r_vs_p2;
  assign bus.vga_blank_n = r_act_p2;
  assign bus.vga_r       = r_r_p2;
  assign bus.vga_g       = r_g_p2;
  assign bus.vga_b       = r_b_p2;
  assign bus.frame_start = w_frame_start;
  // Upstream write gating wants the live line number, not the pipelined one.
  assign bus.vblank      = (w_vcount >= L_V_ACT);

endmodule
